// File: rtl/i2c_pkg.sv
// Shared types and helpers for the I2C single-byte write sequencer.
//   state_t    : frame sequencing states
//   quarter_t  : position inside one SCL bit slot
//   I2C_WRITE  : R/W bit value appended to the 7-bit address
//   slot_lines : pull-low enables {scl_oe, sda_oe} for a given slot/quarter
package i2c_pkg;

  typedef enum logic [2:0] {IDLE, START, ADDR, ACK1, DATA, ACK2, STOP} state_t;
  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quarter_t;

  localparam logic I2C_WRITE = 1'b0;

  // Line pattern for one quarter of a slot. bval is the bit being sent in a
  // data slot (ignored elsewhere). Returns {scl_oe, sda_oe}, 1 = pull low.
  function automatic logic [1:0] slot_lines(input state_t st, input quarter_t q,
                                            input logic bval);
    logic scl_low;
    scl_low = (q == Q0) || (q == Q1);
    case (st)
      START: begin
        case (q)
          Q0, Q1:  slot_lines = 2'b00;
          Q2:      slot_lines = 2'b01;   // SDA falls while SCL is high
          default: slot_lines = 2'b11;
        endcase
      end
      ADDR, DATA: slot_lines = {scl_low, ~bval};
      ACK1, ACK2: slot_lines = {scl_low, 1'b0};
      STOP: begin
        case (q)
          Q0:      slot_lines = 2'b11;
          Q1, Q2:  slot_lines = 2'b01;
          default: slot_lines = 2'b00;   // SDA rises while SCL is high
        endcase
      end
      default: slot_lines = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-period divider for the I2C write sequencer.
// Emits a one-clock tick on the last clock of every CLK_DIV-clock quarter.
//   clk     : system clock
//   reset   : asynchronous active-low reset
//   restart : realign the divider so the next clock is the first of a quarter
//   tick    : high on the last clock of the current quarter
module i2c_quarter_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (restart || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A restart cycle is never the end of a quarter.
  assign tick = (cnt == LAST) && !restart;

endmodule

// File: rtl/i2c_write_sequencer.sv
// Master-side single-byte I2C write frame sequencer:
// START, {addr,W}, ACK, data, ACK, STOP on open-drain lines via pull-low enables.
//   clk       : system clock
//   reset     : asynchronous active-low reset (releases both lines at once)
//   start_req : frame request, accepted only when idle
//   dev_addr  : 7-bit slave address, latched at acceptance
//   wdata     : data byte, latched at acceptance
//   sda_in    : sampled SDA level for ACK detection
//   scl_oe    : 1 = pull SCL low
//   sda_oe    : 1 = pull SDA low
//   busy      : frame in progress
//   done      : one-clock pulse after STOP completes
//   nack      : sticky NACK flag for the last frame
module i2c_write_sequencer
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_req,
  input  logic [6:0] dev_addr,
  input  logic [7:0] wdata,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       nack
);

  state_t     state, nstate;
  quarter_t   qtr, nqtr;
  logic [2:0] bit_idx, nbit;
  logic [7:0] addr_byte, data_byte;
  logic       tick, accept, nbit_val, ack_sample;
  logic [1:0] nlines;

  assign accept = (state == IDLE) && start_req;

  // ACK is judged on the last clock of Q2, while SCL is released.
  assign ack_sample = ((state == ACK1) || (state == ACK2)) && (qtr == Q2) && tick;

  i2c_quarter_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (accept),
    .tick    (tick)
  );

  always_comb begin
    nstate = state;
    nqtr   = qtr;
    nbit   = bit_idx;
    if (accept) begin
      nstate = START;
      nqtr   = Q0;
      nbit   = 3'd0;
    end else if ((state != IDLE) && tick) begin
      case (qtr)
        Q0:      nqtr = Q1;
        Q1:      nqtr = Q2;
        Q2:      nqtr = Q3;
        default: nqtr = Q0;
      endcase
      if (qtr == Q3) begin
        case (state)
          START: begin
            nstate = ADDR;
            nbit   = 3'd0;
          end
          // bit_idx wraps 7 -> 0 on the byte boundary, ready for the next byte.
          ADDR: begin
            nbit = bit_idx + 3'd1;
            if (bit_idx == 3'd7) nstate = ACK1;
          end
          // nack was cleared at acceptance, so here it reflects ACK1 only.
          ACK1: nstate = nack ? STOP : DATA;
          DATA: begin
            nbit = bit_idx + 3'd1;
            if (bit_idx == 3'd7) nstate = ACK2;
          end
          ACK2:    nstate = STOP;
          STOP:    nstate = IDLE;
          default: nstate = IDLE;
        endcase
      end
    end
  end

  // Outputs are registered from the next-state view so each quarter's line
  // pattern is present for the whole quarter; bits go out MSB first.
  assign nbit_val = (nstate == DATA) ? data_byte[~nbit] : addr_byte[~nbit];
  assign nlines   = slot_lines(nstate, nqtr, nbit_val);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      qtr     <= Q0;
      bit_idx <= 3'd0;
      scl_oe  <= 1'b0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      nack    <= 1'b0;
    end else begin
      state              <= nstate;
      qtr                <= nqtr;
      bit_idx            <= nbit;
      {scl_oe, sda_oe}   <= nlines;
      busy               <= (nstate != IDLE);
      done               <= (state == STOP) && (qtr == Q3) && tick;
      if (accept) begin
        nack <= 1'b0;
      end else if (ack_sample && sda_in) begin
        nack <= 1'b1;
      end
    end
  end

  // Frame payload is plain data: latched on acceptance, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_byte <= {dev_addr, I2C_WRITE};
      data_byte <= wdata;
    end
  end

endmodule

// File: doc/i2c_write_sequencer.md
# i2c_write_sequencer

Master-side controller that sequences a complete single-byte I2C write frame on the shared open-drain SDA/SCL lines. The frame is START, 7-bit address plus W, ACK, data byte, ACK, STOP. It sits between the tag's register/command logic and the pad-level SDA/SCL drivers, and generates start/stop conditions, bit timing and ACK sampling. It drives the lines only through pull-low enables, so it coexists with the line's tri-state data path.

## Interface
- CLK_DIV, 4, system clocks per SCL quarter-period; legal range ≥ 2.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start_req  in  1  request a frame; accepted only when busy=0.
- dev_addr  in  7  slave address; latched at acceptance.
- wdata  in  8  data byte; latched at acceptance.
- sda_in  in  1  sampled SDA line level, used for ACK detection.
- scl_oe  out  1  1 = pull SCL low; 0 = release.
- sda_oe  out  1  1 = pull SDA low; 0 = release.
- busy  out  1  frame in progress.
- done  out  1  one-clock pulse at frame end.
- nack  out  1  sticky: last frame saw a NACK; cleared at next acceptance.

## Operation
- Reset values: scl_oe=0, sda_oe=0, busy=0, done=0, nack=0, state IDLE. Assertion releases both lines immediately, including mid-frame.
- Acceptance: in IDLE with start_req=1, latch {dev_addr,1'b0} and wdata, clear nack, restart the divider, set busy=1 on the next clock. start_req while busy=1 is ignored.
- Divider: a tick every CLK_DIV clocks. Each bit slot is 4 quarters, Q0–Q3.
- States: IDLE → START → ADDR (8 slots) → ACK1 → DATA (8 slots) → ACK2 → STOP → IDLE.
- START slot: Q0–Q1 both lines released; Q2 sda_oe=1 with SCL released; Q3 both pulled low.
- Data slots (ADDR, DATA): bits are sent MSB first; bit value 0 gives sda_oe=1, and 1 gives sda_oe=0.
  - sda_oe updates only at the start of Q0.
  - scl_oe=1 in Q0–Q1, 0 in Q2–Q3.
- ACK slots: sda_oe=0, with SCL timing as for data slots. sda_in is sampled on the last clock of Q2; 0 = ACK, 1 = NACK.
- NACK in ACK1: set nack=1, skip DATA and ACK2, go to STOP. NACK in ACK2: set nack=1, go to STOP.
- STOP slot:
  - Q0: scl_oe=1, sda_oe=1.
  - Q1–Q2: SCL released, sda_oe=1.
  - Q3: both released.
- After STOP Q3 ends: done=1 for one clock, busy=0 in the same clock, return to IDLE.
- Slot counters: bit index is 3 bits, wrapping 7→0 at the byte boundary. Quarter counter is 2 bits. Divider counter is $clog2(CLK_DIV) bits.

## Timing
- First START quarter begins the clock after acceptance.
- Full ACKed frame is 20 slots = 80·CLK_DIV clocks; done is high on the following clock. CLK_DIV=4 gives done at acceptance + 321 clocks.
- Address-NACK frame is 11 slots = 44·CLK_DIV clocks, giving done at acceptance + 177 clocks with CLK_DIV=4.
- SDA never changes while SCL is released, except the intended START and STOP edges.
- start_req held high through done: the next frame is accepted the clock after done, so back-to-back frames have no idle slot.
- Reset mid-frame: outputs return to reset values asynchronously. The next start_req after release is accepted normally.

## Structure
- Package i2c_pkg holds:
  - state enum {IDLE, START, ADDR, ACK1, DATA, ACK2, STOP};
  - quarter enum {Q0, Q1, Q2, Q3};
  - constant I2C_WRITE = 1'b0.
- Sub-module i2c_quarter_tick: CLK_DIV divider with restart input and one-clock tick output. The FSM stays in the top module.

## Test plan
- Reset: hold reset=0 with random inputs → scl_oe=0, sda_oe=0, busy=0, done=0, nack=0.
- Full write, dev_addr=0x50, wdata=0xA5, CLK_DIV=4, sda_in=0 in ACK slots:
  - sda_oe sampled on SCL-high quarters decodes to 0xA0 then 0xA5;
  - done at +321 clocks, nack=0.
- Address NACK, sda_in=1 throughout → no DATA slots, STOP issued, done at +177 clocks, nack=1.
- start_req pulsed mid-frame with different dev_addr/wdata → ignored; the frame completes with the originally latched values.
- reset asserted during DATA bit 3 → lines released the same cycle. A new request after release runs a clean full frame.
- start_req held high across two frames → second START begins the clock after the first done; nack reflects the second frame only.
